ex_div: RTL



---
 rtl/ex_div.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ex_div.sv
// Radix-2 restoring integer divider for the EX stage: one quotient bit per clock, signed/unsigned.
// Define EX_DIV_ZERO_FAST_EN to finish divide-by-zero in one step instead of the constant-time path.
module ex_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 start,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BYZERO,
        ST_ON,
        ST_END
    } state_t;

    state_t               r_state, w_state;
    logic [2*WIDTH-1:0]   r_acc, w_acc;
    logic [WIDTH-1:0]     r_divisor, w_divisor;
    logic [WIDTH-1:0]     r_op1, w_op1;
    logic [CNT_W-1:0]     r_cnt, w_cnt;
    logic                 r_sgn_q, w_sgn_q;
    logic                 r_sgn_r, w_sgn_r;
    logic [2*WIDTH-1:0]   r_result, w_result;
    logic                 r_ready, w_ready;

    logic [WIDTH:0]       w_top;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_iter;
    logic [WIDTH-1:0]     w_quo, w_rem;
    logic [WIDTH-1:0]     w_abs1, w_abs2;
    logic [2*WIDTH-1:0]   w_zero_res;
    logic                 w_last, w_abort;

    // r_acc holds {partial remainder, dividend}; the shifted-out dividend bits become the quotient.
    assign w_top      = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_top - {1'b0, r_divisor};
    assign w_iter     = w_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    assign w_quo      = r_sgn_q ? -w_iter[WIDTH-1:0] : w_iter[WIDTH-1:0];
    assign w_rem      = r_sgn_r ? -w_iter[2*WIDTH-1:WIDTH] : w_iter[2*WIDTH-1:WIDTH];
    assign w_abs1     = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    assign w_abs2     = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    assign w_zero_res = {r_op1, {WIDTH{1'b1}}};
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_abort    = !start || annul;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_divisor <= '0;
            r_op1     <= '0;
            r_cnt     <= '0;
            r_sgn_q   <= 1'b0;
            r_sgn_r   <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_acc     <= w_acc;
            r_divisor <= w_divisor;
            r_op1     <= w_op1;
            r_cnt     <= w_cnt;
            r_sgn_q   <= w_sgn_q;
            r_sgn_r   <= w_sgn_r;
            r_result  <= w_result;
            r_ready   <= w_ready;
        end
    end

    // result is loaded on entry to END; ready follows one edge later and both clear on leaving END.
    always_comb begin
        w_state   = r_state;
        w_acc     = r_acc;
        w_divisor = r_divisor;
        w_op1     = r_op1;
        w_cnt     = r_cnt;
        w_sgn_q   = r_sgn_q;
        w_sgn_r   = r_sgn_r;
        w_result  = '0;
        w_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !annul) begin
                    w_acc     = {{WIDTH{1'b0}}, w_abs1};
                    w_divisor = w_abs2;
                    w_op1     = opdata1;
                    w_cnt     = '0;
                    w_sgn_q   = signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                    w_sgn_r   = signed_div && opdata1[WIDTH-1];
                    w_state   = (opdata2 == '0) ? ST_BYZERO : ST_ON;
                end
            end
            ST_ON: begin
                if (w_abort) begin
                    w_state = ST_IDLE;
                end else begin
                    w_acc = w_iter;
                    w_cnt = r_cnt + CNT_W'(1);
                    if (w_last) begin
                        w_state  = ST_END;
                        w_result = {w_rem, w_quo};
                    end
                end
            end
            ST_BYZERO: begin
                if (w_abort) begin
                    w_state = ST_IDLE;
                end else begin
`ifdef EX_DIV_ZERO_FAST_EN
                    w_state  = ST_END;
                    w_result = w_zero_res;
`else
                    w_cnt = r_cnt + CNT_W'(1);
                    if (w_last) begin
                        w_state  = ST_END;
                        w_result = w_zero_res;
                    end
`endif
                end
            end
            ST_END: begin
                if (w_abort) begin
                    w_state = ST_IDLE;
                end else begin
                    w_result = r_result;
                    w_ready  = 1'b1;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    assign result = r_result;
    assign ready  = r_ready;

endmodule
